// File: rtl/chained_input_buffer.sv
// Trace input queue that replays each stored {eof, vector} entry once per configured chain.
// Read path is a registered RAM read (s1) followed by the presentation register.
module chained_input_buffer #(
  parameter int N                = 8,
  parameter int DATA_WIDTH       = 32,
  parameter int IB_DEPTH         = 4,
  parameter int MAX_CHAINS       = 4,
  parameter int INITIAL_FIRMWARE = 0,
  parameter int IB_CONFIG_ID     = 0,
  parameter int AF_THRESH        = IB_DEPTH - 1,
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
  localparam int OW = $clog2(IB_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enqueue,
  input  logic                             eof_in,
  input  logic                             tracing,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  input  logic                             stall,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  output logic                             valid_out,
  output logic                             eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic [CW-1:0]                    chainId_out,
  output logic                             full,
  output logic                             almost_full,
  output logic [OW-1:0]                    occupancy,
  output logic [15:0]                      overflow_count
);

  localparam int PW = $clog2(IB_DEPTH);
  localparam int EW = N * DATA_WIDTH + 1;

  logic [EW-1:0] mem_q [IB_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic [15:0]   ovf_q, ovf_d;
  logic [7:0]    vc_q, vc_d;
  logic          s1_valid_q, s1_valid_d;
  logic [EW-1:0] s1_data_q, s1_data_d;
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] chain_q, chain_d;
  logic [CW-1:0] last_q, last_d;

  logic          accept, drop, at_last, pop, out_take, out_load, mem_avail, s1_load;
  logic [OW-1:0] in_flight;
  logic [CW-1:0] eff_last;

  // Last chain index for an entry starting now: valid_chains clamped to [1, MAX_CHAINS], minus one.
  always_comb begin
    eff_last = '0;
    if (vc_q == 8'd0) begin
      eff_last = '0;
    end else if (int'(vc_q) >= MAX_CHAINS) begin
      eff_last = CW'(MAX_CHAINS - 1);
    end else begin
      eff_last = CW'(vc_q - 8'd1);
    end
  end

  always_comb begin
    accept    = enqueue & tracing & ~full_q;
    drop      = enqueue & tracing & full_q;
    at_last   = (chain_q == last_q);
    pop       = out_valid_q & ~stall & at_last;
    out_take  = ~stall & (~out_valid_q | at_last);
    out_load  = out_take & s1_valid_q;
    // Entries still in RAM are those counted in occupancy but not yet pulled into s1 or the output.
    in_flight = OW'(s1_valid_q) + OW'(out_valid_q);
    mem_avail = (occ_q > in_flight);
    s1_load   = mem_avail & (~s1_valid_q | out_load);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    ovf_d       = ovf_q;
    vc_d        = vc_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    chain_d     = chain_q;
    last_d      = last_q;

    if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (s1_load) rd_ptr_d = rd_ptr_q + PW'(1);

    if (accept && !pop) begin
      occ_d = occ_q + OW'(1);
    end else if (pop && !accept) begin
      occ_d = occ_q - OW'(1);
    end

    if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    if (configId == 8'(IB_CONFIG_ID)) vc_d = configData;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_data_d  = mem_q[rd_ptr_q];
    end else if (out_load) begin
      s1_valid_d = 1'b0;
    end

    if (out_take) begin
      out_valid_d = s1_valid_q;
      chain_d     = '0;
      if (s1_valid_q) begin
        out_data_d = s1_data_q;
        last_d     = eff_last;
      end
    end else if (out_valid_q && !stall) begin
      chain_d = chain_q + CW'(1);
    end

    full_d = (int'(occ_d) == IB_DEPTH);
    af_d   = (int'(occ_d) >= AF_THRESH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      af_q        <= (AF_THRESH == 0);
      ovf_q       <= '0;
      vc_q        <= 8'(INITIAL_FIRMWARE);
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      chain_q     <= '0;
      last_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      af_q        <= af_d;
      ovf_q       <= ovf_d;
      vc_q        <= vc_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      chain_q     <= chain_d;
      last_q      <= last_d;
    end
  end

  // Storage is not reset; the pointers and occupancy decide what is live.
  always_ff @(posedge clk) begin
    if (!reset && accept) mem_q[wr_ptr_q] <= {eof_in, vector_in};
  end

  assign valid_out      = out_valid_q;
  assign eof_out        = out_data_q[EW-1];
  assign vector_out     = out_data_q[EW-2:0];
  assign chainId_out    = chain_q;
  assign full           = full_q;
  assign almost_full    = af_q;
  assign occupancy      = occ_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_chained_input_buffer.sv
// Self-checking bench: directed literal checks plus randomized traffic against a queue-based model.
module tb_chained_input_buffer;

  localparam int N      = 8;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int MAXC   = 4;
  localparam int INITFW = 3;
  localparam int CFGID  = 0;
  localparam int AF     = DEPTH - 1;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t   data;
    bit     eof;
    longint acc;
  } ent_t;

  logic        clk;
  logic        reset, enqueue, eof_in, tracing, stall;
  logic [7:0]  configId, configData;
  vec_t        vector_in;
  logic        valid_out, eof_out, full, almost_full;
  vec_t        vector_out;
  logic [1:0]  chainId_out;
  logic [2:0]  occupancy;
  logic [15:0] overflow_count;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  chained_input_buffer #(
    .N(N), .DATA_WIDTH(DW), .IB_DEPTH(DEPTH), .MAX_CHAINS(MAXC),
    .INITIAL_FIRMWARE(INITFW), .IB_CONFIG_ID(CFGID), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .reset(reset), .enqueue(enqueue), .eof_in(eof_in), .tracing(tracing),
    .configId(configId), .configData(configData), .stall(stall), .vector_in(vector_in),
    .valid_out(valid_out), .eof_out(eof_out), .vector_out(vector_out),
    .chainId_out(chainId_out), .full(full), .almost_full(almost_full),
    .occupancy(occupancy), .overflow_count(overflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue of not-yet-finished entries stamped with their accept edge.
  ent_t   mq[$];
  ent_t   new_ent;
  bit     m_valid = 0;
  int     m_chain = 0;
  int     m_nch   = 1;
  int     m_cfg   = INITFW;
  int     m_ovf   = 0;
  int     sz0;
  longint edge_n  = 0;

  function automatic int eff(input int c);
    if (c < 1) return 1;
    if (c > MAXC) return MAXC;
    return c;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      mq.delete();
      m_valid = 0;
      m_chain = 0;
      m_nch   = 1;
      m_cfg   = INITFW;
      m_ovf   = 0;
    end else begin
      sz0 = mq.size();
      if (m_valid && !stall && m_chain == m_nch - 1) void'(mq.pop_front());
      if (enqueue && tracing) begin
        if (sz0 == DEPTH) begin
          if (m_ovf < 16'hFFFF) m_ovf++;
        end else begin
          new_ent.data = vector_in;
          new_ent.eof  = eof_in;
          new_ent.acc  = edge_n;
          mq.push_back(new_ent);
        end
      end
      // An entry can be shown no earlier than two edges after it was accepted.
      if (!stall) begin
        if (m_valid && m_chain != m_nch - 1) begin
          m_chain++;
        end else if (mq.size() > 0 && mq[0].acc <= edge_n - 2) begin
          m_valid = 1;
          m_chain = 0;
          m_nch   = eff(m_cfg);
        end else begin
          m_valid = 0;
          m_chain = 0;
        end
      end
      if (configId == 8'(CFGID)) m_cfg = configData;
    end
  end

  task automatic checkOutput(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("valid_out", 256'(valid_out), 256'(m_valid));
      if (m_valid) begin
        checkOutput("chainId_out", 256'(chainId_out), 256'(m_chain));
        checkOutput("eof_out", 256'(eof_out), 256'(mq[0].eof));
        checkOutput("vector_out", 256'(vector_out), 256'(mq[0].data));
      end
      checkOutput("occupancy", 256'(occupancy), 256'(mq.size()));
      checkOutput("full", 256'(full), 256'(mq.size() == DEPTH));
      checkOutput("almost_full", 256'(almost_full), 256'(mq.size() >= AF));
      checkOutput("overflow_count", 256'(overflow_count), 256'(m_ovf));
    end
  end

  // Drives one cycle of inputs and returns at the following negedge.
  task automatic applyStimulus(input bit rst, input bit enq, input bit eof, input bit trc,
                               input logic [7:0] cid, input logic [7:0] cdat,
                               input bit stl, input vec_t vec);
    reset      = rst;
    enqueue    = enq;
    eof_in     = eof;
    tracing    = trc;
    configId   = cid;
    configData = cdat;
    stall      = stl;
    vector_in  = vec;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit stl);
    applyStimulus(0, 0, 0, 1, 8'hFF, 8'h00, stl, '0);
  endtask

  vec_t lit, rv;
  int   stall_pct;

  initial begin
    reset = 1; enqueue = 0; eof_in = 0; tracing = 1;
    configId = 8'hFF; configData = 0; stall = 0; vector_in = '0;
    @(negedge clk);
    applyStimulus(1, 1, 0, 1, 8'hFF, 8'h00, 0, '0);
    applyStimulus(1, 0, 0, 1, 8'hFF, 8'h00, 0, '0);
    chk_en = 1;
    checkOutput("rst valid_out", 256'(valid_out), 256'(0));
    checkOutput("rst eof_out", 256'(eof_out), 256'(0));
    checkOutput("rst vector_out", 256'(vector_out), 256'(0));
    checkOutput("rst chainId_out", 256'(chainId_out), 256'(0));
    checkOutput("rst occupancy", 256'(occupancy), 256'(0));
    checkOutput("rst overflow_count", 256'(overflow_count), 256'(0));

    // Single entry replayed three times (INITIAL_FIRMWARE = 3).
    for (int i = 0; i < N; i++) lit[i] = 32'(i + 1);
    idle(0);
    applyStimulus(0, 1, 1, 1, 8'hFF, 8'h00, 0, lit);
    checkOutput("basic occ after accept", 256'(occupancy), 256'(1));
    checkOutput("basic valid at +0", 256'(valid_out), 256'(0));
    idle(0);
    checkOutput("basic valid at +1", 256'(valid_out), 256'(0));
    for (int c = 0; c < 3; c++) begin
      idle(0);
      checkOutput("basic valid", 256'(valid_out), 256'(1));
      checkOutput("basic chain", 256'(chainId_out), 256'(c));
      checkOutput("basic eof", 256'(eof_out), 256'(1));
      checkOutput("basic vector", 256'(vector_out), 256'(lit));
    end
    idle(0);
    checkOutput("basic valid drop", 256'(valid_out), 256'(0));
    checkOutput("basic occ drained", 256'(occupancy), 256'(0));

    // Overflow while stalled with one chain per entry.
    applyStimulus(0, 0, 0, 1, 8'(CFGID), 8'd1, 1, '0);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) rv[i] = 32'(16 * k + i);
      applyStimulus(0, 1, k[0], 1, 8'hFF, 8'h00, 1, rv);
      if (k == 3) checkOutput("ovf full after 4th", 256'(full), 256'(1));
    end
    checkOutput("ovf count", 256'(overflow_count), 256'(2));
    checkOutput("ovf occupancy", 256'(occupancy), 256'(4));
    for (int k = 0; k < 8; k++) idle(0);
    checkOutput("ovf drained", 256'(occupancy), 256'(0));

    // Randomized traffic with alternating stall pressure and occasional resets.
    stall_pct = 10;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int  sel;
      bit  rst;
      logic [7:0] cid;
      if (cyc % 200 == 0) stall_pct = (stall_pct == 10) ? 70 : 10;
      for (int i = 0; i < N; i++) rv[i] = $urandom();
      sel = $urandom_range(0, 99);
      cid = (sel < 4) ? 8'(CFGID) : ((sel < 6) ? 8'd1 : 8'hFF);
      rst = ($urandom_range(0, 299) == 0);
      applyStimulus(rst, ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) != 0), cid, 8'($urandom_range(0, 9)),
                    ($urandom_range(0, 99) < stall_pct), rv);
    end
    for (int k = 0; k < 20; k++) idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
